// File: rtl/ar_req_arbiter.sv
// Round-robin AR request arbiter with internal tag allocation and tag recycling.
// Optional build macro AR_ARB_QOS_EN restricts competition to the highest-QoS valid requesters.
module ar_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  in_len,
  input  logic [NUM_REQ*3-1:0]          in_size,
  input  logic [NUM_REQ*2-1:0]          in_burst,
  input  logic [NUM_REQ*4-1:0]          in_qos,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [LEN_WIDTH-1:0]          out_len,
  output logic [2:0]                    out_size,
  output logic [1:0]                    out_burst,
  output logic [3:0]                    out_qos,
  output logic [TAG_WIDTH-1:0]          out_tagid,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          rel_valid,
  input  logic [TAG_WIDTH-1:0]          rel_tag,
  output logic [TAG_WIDTH:0]            tags_busy,
  output logic                          tag_err
);

  localparam int NUM_TAGS = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] CNT_ONE = 1;

  // Handshakes: a beat transfers on a clock edge where valid && ready are both high;
  // valid never depends on ready, and the output beat is held stable until accepted.

  logic [ID_WIDTH-1:0]   id_a    [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [LEN_WIDTH-1:0]  len_a   [NUM_REQ];
  logic [2:0]            size_a  [NUM_REQ];
  logic [1:0]            burst_a [NUM_REQ];
  logic [3:0]            qos_a   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign id_a[k]    = in_id[k*ID_WIDTH +: ID_WIDTH];
    assign addr_a[k]  = in_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[k]   = in_len[k*LEN_WIDTH +: LEN_WIDTH];
    assign size_a[k]  = in_size[k*3 +: 3];
    assign burst_a[k] = in_burst[k*2 +: 2];
    assign qos_a[k]   = in_qos[k*4 +: 4];
  end

  logic [SRC_W-1:0]    rr_ptr;
  logic [NUM_TAGS-1:0] tag_map;
  logic [NUM_REQ-1:0]  elig;
  logic [SRC_W-1:0]    win;
  logic [TAG_WIDTH-1:0] free_tag;
  logic                free_any;
  logic                stage_open;
  logic                grant;
  logic                rel_ok;
  logic                rel_bad;
  logic [NUM_TAGS-1:0] set_mask;
  logic [NUM_TAGS-1:0] clr_mask;
  int                  scan_idx;

`ifdef AR_ARB_QOS_EN
  logic [3:0] max_qos;

  always_comb begin
    max_qos = '0;
    elig    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (in_valid[k] && (qos_a[k] > max_qos)) max_qos = qos_a[k];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = in_valid[k] && (qos_a[k] == max_qos);
    end
  end
`else
  assign elig = in_valid;
`endif

  // Scan downwards so the last hit is the first eligible requester at or after rr_ptr.
  always_comb begin
    win      = '0;
    scan_idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (elig[scan_idx]) win = SRC_W'(scan_idx);
    end
  end

  always_comb begin
    free_tag = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!tag_map[t]) free_tag = TAG_WIDTH'(t);
    end
  end

  assign free_any   = ~&tag_map;
  assign stage_open = !out_valid || out_ready;
  assign grant      = stage_open && free_any && (|in_valid);
  assign rel_ok     = rel_valid && tag_map[rel_tag];
  assign rel_bad    = rel_valid && !tag_map[rel_tag];
  assign set_mask   = grant  ? (NUM_TAGS'(1) << free_tag) : '0;
  assign clr_mask   = rel_ok ? (NUM_TAGS'(1) << rel_tag)  : '0;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_addr  <= '0;
      out_len   <= '0;
      out_size  <= '0;
      out_burst <= '0;
      out_qos   <= '0;
      out_tagid <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_id    <= id_a[win];
      out_addr  <= addr_a[win];
      out_len   <= len_a[win];
      out_size  <= size_a[win];
      out_burst <= burst_a[win];
      out_qos   <= qos_a[win];
      out_tagid <= free_tag;
      out_src   <= win;
      rr_ptr    <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Grant only ever sets a free tag and release only clears a busy one, so masks never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_map   <= '0;
      tags_busy <= '0;
      tag_err   <= 1'b0;
    end else begin
      tag_map <= (tag_map | set_mask) & ~clr_mask;
      case ({grant, rel_ok})
        2'b10:   tags_busy <= tags_busy + CNT_ONE;
        2'b01:   tags_busy <= tags_busy - CNT_ONE;
        default: tags_busy <= tags_busy;
      endcase
      if (rel_bad) tag_err <= 1'b1;
    end
  end

endmodule
